// File: rtl/acc_mult_seq.sv
// Shift-add unsigned multiplier with a (2*WIDTH+1)-bit accumulator, manual
// Load/Sh/Ad commands in IDLE and an internal Start-driven sequencer.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting; Start > Load > Ad > Sh, at most one action per cycle
// S_ADD   | add captured multiplicand into upper half if ACC[0] is set
// S_SHIFT | logical right shift of ACC, advance bit counter
// S_DONE  | one-cycle completion pulse, ACC held, all commands ignored
module acc_mult_seq #(
    parameter int WIDTH = 4
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Start,
    input  logic [WIDTH-1:0]   Multiplicando,
    input  logic [WIDTH-1:0]   Multiplicador,
    input  logic               Load,
    input  logic               Sh,
    input  logic               Ad,
    input  logic [2*WIDTH:0]   Entradas,
    output logic [2*WIDTH:0]   Saidas,
    output logic [2*WIDTH-1:0] Produto,
    output logic               Busy,
    output logic               Done
);

    localparam int AW = 2*WIDTH + 1;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CW-1:0]    count_q, count_d;

    logic             last_shift;
    logic [WIDTH-1:0] add_m;
    logic [WIDTH:0]   add_sum;
    logic [AW-1:0]    acc_added;
    logic [AW-1:0]    acc_shifted;

    assign last_shift = (count_q == CW'(WIDTH-1));

    // Manual Ad uses the live port; the sequencer uses the captured operand.
    assign add_m       = (state_q == S_IDLE) ? Multiplicando : mcand_q;
    assign add_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, add_m};
    assign acc_added   = {add_sum, acc_q[WIDTH-1:0]};
    assign acc_shifted = {1'b0, acc_q[AW-1:1]};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Start) state_d = S_ADD;
            S_ADD:   state_d = S_SHIFT;
            S_SHIFT: state_d = last_shift ? S_DONE : S_ADD;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        case (state_q)
            S_ADD, S_SHIFT: Busy = 1'b1;
            S_DONE:         Done = 1'b1;
            default:        ;
        endcase
    end

    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    acc_d   = {{(WIDTH+1){1'b0}}, Multiplicador};
                    mcand_d = Multiplicando;
                    count_d = '0;
                end else if (Load) begin
                    acc_d = Entradas;
                end else if (Ad) begin
                    acc_d = acc_added;
                end else if (Sh) begin
                    acc_d = acc_shifted;
                end
            end
            S_ADD: begin
                if (acc_q[0]) acc_d = acc_added;
            end
            S_SHIFT: begin
                acc_d = acc_shifted;
                // Counter saturates at WIDTH-1; the FSM leaves SHIFT then.
                if (!last_shift) count_d = count_q + CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            acc_q   <= '0;
            mcand_q <= '0;
            count_q <= '0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            count_q <= count_d;
        end
    end

    assign Saidas  = acc_q;
    assign Produto = acc_q[2*WIDTH-1:0];

endmodule

// File: tb/tb_acc_mult_seq.sv
// Directed and randomised checks of acc_mult_seq at WIDTH=4 and WIDTH=8.
module tb_acc_mult_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       st4 = 0, ld4 = 0, sh4 = 0, ad4 = 0;
    logic [3:0] mc4 = 0, mp4 = 0;
    logic [8:0] en4 = 0;
    logic [8:0] sa4;
    logic [7:0] pr4;
    logic       bz4, dn4;

    logic        st8 = 0, ld8 = 0, sh8 = 0, ad8 = 0;
    logic [7:0]  mc8 = 0, mp8 = 0;
    logic [16:0] en8 = 0;
    logic [16:0] sa8;
    logic [15:0] pr8;
    logic        bz8, dn8;

    acc_mult_seq #(.WIDTH(4)) dut4 (
        .Clk(clk), .Rst_n(rst_n), .Start(st4), .Multiplicando(mc4),
        .Multiplicador(mp4), .Load(ld4), .Sh(sh4), .Ad(ad4), .Entradas(en4),
        .Saidas(sa4), .Produto(pr4), .Busy(bz4), .Done(dn4)
    );

    acc_mult_seq #(.WIDTH(8)) dut8 (
        .Clk(clk), .Rst_n(rst_n), .Start(st8), .Multiplicando(mc8),
        .Multiplicador(mp8), .Load(ld8), .Sh(sh8), .Ad(ad8), .Entradas(en8),
        .Saidas(sa8), .Produto(pr8), .Busy(bz8), .Done(dn8)
    );

    logic        sel8 = 1'b0;
    logic [16:0] sa_s;
    logic [15:0] pr_s;
    logic        bz_s, dn_s, msb_s;
    assign sa_s  = sel8 ? sa8 : {8'b0, sa4};
    assign pr_s  = sel8 ? pr8 : {8'b0, pr4};
    assign bz_s  = sel8 ? bz8 : bz4;
    assign dn_s  = sel8 ? dn8 : dn4;
    assign msb_s = sel8 ? sa8[16] : sa4[8];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the first
    // IDLE cycle after Done so a following call starts back-to-back.
    // mode 0: plain, 1: hammer commands while busy, 2: Start together with Load
    task automatic run_mult(input bit w8, input int a, input int b, input int expv, input int mode);
        int w;
        int busy_n, done_n, done_at, both;
        w = w8 ? 8 : 4;
        busy_n = 0; done_n = 0; done_at = 0; both = 0;
        sel8 = w8;
        if (w8) begin
            mc8 = 8'(a); mp8 = 8'(b); st8 = 1'b1;
        end else begin
            mc4 = 4'(a); mp4 = 4'(b); st4 = 1'b1;
            if (mode == 2) begin ld4 = 1'b1; en4 = 9'h1FF; end
        end
        @(negedge clk);
        st4 = 1'b0; st8 = 1'b0; ld4 = 1'b0;
        for (int c = 1; c <= 2*w + 2; c++) begin
            if (bz_s) busy_n++;
            if (bz_s && dn_s) both++;
            if (dn_s) begin
                done_n++;
                if (done_at == 0) begin
                    done_at = c;
                    check($sformatf("product %0dx%0d", a, b), 32'(pr_s), 32'(expv));
                    check("acc_msb_at_done", 32'(msb_s), 32'd0);
                end
            end
            if (mode == 2 && c == 1)
                check("start_beats_load", 32'(sa_s), 32'(b));
            if (c == 2*w + 2) begin
                check("produto_hold_idle", 32'(pr_s), 32'(expv));
                check("busy_low_idle", 32'(bz_s), 32'd0);
            end
            if (mode == 1) begin
                if (c <= 2*w) begin
                    st4 = 1'b1; ld4 = 1'b1; ad4 = 1'b1; sh4 = 1'b1; en4 = 9'h1FF;
                    mc4 = 4'($urandom_range(0, 15));
                    mp4 = 4'($urandom_range(0, 15));
                end else begin
                    st4 = 1'b0; ld4 = 1'b0; ad4 = 1'b0; sh4 = 1'b0;
                end
            end
            if (c < 2*w + 2) @(negedge clk);
        end
        check("busy_cycles", 32'(busy_n), 32'(2*w));
        check("done_cycle", 32'(done_at), 32'(2*w + 1));
        check("done_count", 32'(done_n), 32'd1);
        check("busy_and_done", 32'(both), 32'd0);
    endtask

    typedef struct {
        logic       st, ld, ad, sh;
        logic [3:0] mc, mp;
        logic [8:0] en;
        logic [8:0] exp;
    } man_vec_t;

    man_vec_t tbl[12];

    initial begin
        int a, b;
        //               st ld ad sh  mc     mp     en        exp
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 9'h157, 9'h157};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 4'h0, 9'h000, 9'h087};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 4'h0, 9'h000, 9'h043};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 4'h0, 9'h000, 9'h073};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h9, 4'h6, 9'h1FF, 9'h073};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 9'h1FF, 9'h1FF};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 9'h000, 9'h1EF};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 9'h000, 9'h0F7};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 9'h100, 9'h100};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 4'h0, 9'h000, 9'h020};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 4'h0, 9'h0AA, 9'h0AA};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 4'h0, 9'h000, 9'h0FA};

        repeat (2) @(negedge clk);
        check("rst_saidas4", 32'(sa4), 32'd0);
        check("rst_busy4", 32'(bz4), 32'd0);
        check("rst_done4", 32'(dn4), 32'd0);
        check("rst_saidas8", 32'(sa8), 32'd0);
        check("rst_done8", 32'(dn8), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            st4 = tbl[i].st; ld4 = tbl[i].ld; ad4 = tbl[i].ad; sh4 = tbl[i].sh;
            mc4 = tbl[i].mc; mp4 = tbl[i].mp; en4 = tbl[i].en;
            @(negedge clk);
            check($sformatf("manual[%0d] saidas", i), 32'(sa4), 32'(tbl[i].exp));
            check($sformatf("manual[%0d] produto", i), 32'(pr4), 32'(tbl[i].exp[7:0]));
        end
        st4 = 0; ld4 = 0; ad4 = 0; sh4 = 0;
        @(negedge clk);

        run_mult(1'b0, 13, 11, 'h8F, 0);
        run_mult(1'b0, 15, 15, 'hE1, 0);
        run_mult(1'b0, 0, 9, 'h00, 0);
        run_mult(1'b0, 13, 11, 'h8F, 1);
        run_mult(1'b0, 13, 11, 'h8F, 2);
        run_mult(1'b1, 255, 255, 'hFE01, 0);
        run_mult(1'b1, 2, 3, 'h0006, 0);

        // Asynchronous reset in the middle of a multiply.
        st4 = 1'b1; mc4 = 4'd13; mp4 = 4'd11;
        @(negedge clk);
        st4 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_rst_saidas", 32'(sa4), 32'd0);
        check("midrun_rst_busy", 32'(bz4), 32'd0);
        check("midrun_rst_done", 32'(dn4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_mult(1'b0, 6, 7, 42, 0);

        for (int i = 0; i < 500; i++) begin
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            run_mult(1'b0, a, b, a * b, 0);
        end
        for (int i = 0; i < 500; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            run_mult(1'b1, a, b, a * b, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
